// File: rtl/user_sm_arbiter.sv
// user_sm_arbiter: packet-level two-class round-robin arbiter that merges four
// user-project AXI-Stream slots onto one registered return channel.
module user_sm_arbiter #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pNUM_REQ    = 4
) (
  input  logic                            ASCLK,
  input  logic                            ARESET_N,
  input  logic [pNUM_REQ-1:0]             rq_tvalid,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0] rq_tdata,
  input  logic [pNUM_REQ*4-1:0]           rq_tstrb,
  input  logic [pNUM_REQ-1:0]             rq_tkeep,
  input  logic [pNUM_REQ-1:0]             rq_tlast,
  input  logic [pNUM_REQ-1:0]             rq_hi_pri,
  input  logic [pNUM_REQ-1:0]             rq_en,
  output logic [pNUM_REQ-1:0]             rq_tready,
  output logic                            sm_tvalid,
  output logic [pDATA_WIDTH-1:0]          sm_tdata,
  output logic [3:0]                      sm_tstrb,
  output logic                            sm_tkeep,
  output logic                            sm_tlast,
  output logic [2:0]                      sm_tid,
  input  logic                            sm_tready,
  output logic                            busy,
  output logic [1:0]                      grant_id
);

  localparam int unsigned NREQ   = pNUM_REQ;
  localparam int unsigned STRB_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;

  logic                   vld_q, vld_d;
  logic [pDATA_WIDTH-1:0] data_q;
  logic [STRB_W-1:0]      strb_q;
  logic                   keep_q;
  logic                   last_q;
  logic [2:0]             tid_q;

  logic [NREQ-1:0]        elig, hi_set, cand;
  logic [1:0]             win, idx;
  logic                   found;

  logic [pDATA_WIDTH-1:0] sel_data;
  logic [STRB_W-1:0]      sel_strb;
  logic                   sel_keep, sel_last, sel_valid;
  logic                   rdy_g, load;

  // Two-class round-robin search starting at rr_ptr, wrapping 3 -> 0
  always_comb begin
    elig   = rq_en & rq_tvalid;
    hi_set = elig & rq_hi_pri;
    cand   = (|hi_set) ? hi_set : elig;
    win    = rr_ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Select the granted slot's beat fields
  always_comb begin
    sel_data  = '0;
    sel_strb  = '0;
    sel_keep  = 1'b0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == 2'(i)) begin
        sel_data  = rq_tdata[i*pDATA_WIDTH +: pDATA_WIDTH];
        sel_strb  = rq_tstrb[i*STRB_W +: STRB_W];
        sel_keep  = rq_tkeep[i];
        sel_last  = rq_tlast[i];
        sel_valid = rq_tvalid[i];
      end
    end
  end

  // Granted slot may push when the output stage is empty or draining
  assign rdy_g = (state_q == S_LOCK) & (~vld_q | sm_tready);
  assign load  = rdy_g & sel_valid;

  // Only the granted slot sees ready
  always_comb begin
    rq_tready = '0;
    if (rdy_g) begin
      rq_tready[grant_q] = 1'b1;
    end
  end

  // Next-state: arbitrate in IDLE, release on accepted tlast in LOCK
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_LOCK;
          grant_d  = win;
          rr_ptr_d = win + 2'd1;
        end
      end
      S_LOCK: begin
        if (load && sel_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output-stage valid: set on load, cleared when drained without reload
  always_comb begin
    vld_d = vld_q;
    if (load) begin
      vld_d = 1'b1;
    end else if (sm_tready) begin
      vld_d = 1'b0;
    end
  end

  // Arbiter state registers
  always_ff @(posedge ASCLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output register; payload only changes on load so it holds while stalled
  always_ff @(posedge ASCLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
      keep_q <= 1'b0;
      last_q <= 1'b0;
      tid_q  <= '0;
    end else begin
      vld_q <= vld_d;
      if (load) begin
        data_q <= sel_data;
        strb_q <= sel_strb;
        keep_q <= sel_keep;
        last_q <= sel_last;
        tid_q  <= {1'b0, grant_q};
      end
    end
  end

  assign sm_tvalid = vld_q;
  assign sm_tdata  = data_q;
  assign sm_tstrb  = strb_q;
  assign sm_tkeep  = keep_q;
  assign sm_tlast  = last_q;
  assign sm_tid    = tid_q;
  assign busy      = (state_q == S_LOCK);
  assign grant_id  = grant_q;

endmodule
